// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman table-build controller: state encodings
// and the width of the merge/split round index.
package huff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_CNTV  = 3'd2,
        ST_SORT  = 3'd3,
        ST_MERGE = 3'd4,
        ST_SPLIT = 3'd5,
        ST_CODEV = 3'd6
    } huff_state_e;

    function automatic int round_w(input int nsym);
        return (nsym < 2) ? 1 : $clog2(nsym);
    endfunction

endpackage

// File: rtl/huff_round_cnt.sv
// Up/down round counter with synchronous load; load has priority over counting.
module huff_round_cnt
    import huff_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         up_i,
    input  logic         down_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (up_i) begin
            cnt_d = cnt_q + W'(1);
        end else if (down_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/huff_ctrl.sv
// Huffman code-table build sequencer: counts a frame of gray samples, then
// steps through sort, merge and split rounds and offers the code table.
module huff_ctrl
    import huff_pkg::*;
#(
    parameter  int NSYM    = 6,
    parameter  int PIX_W   = 16,
    parameter  int MAX_PIX = 2**PIX_W - 1,
    localparam int RW      = round_w(NSYM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gray_valid,
    input  logic             code_ready,
    output logic [2:0]       state,
    output logic [RW-1:0]    round,
    output logic [PIX_W-1:0] pix_cnt,
    output logic             CNT_valid,
    output logic             merge_en,
    output logic             split_en,
    output logic             code_valid,
    output logic             busy,
    output logic             err_ovf,
    output logic             err_drop
);

    localparam logic [PIX_W-1:0] PIX_MAX    = PIX_W'(MAX_PIX);
    localparam logic [RW-1:0]    LAST_MERGE = RW'(NSYM - 2);
    localparam logic [RW-1:0]    RND_ONE    = RW'(1);

    huff_state_e      state_q;
    logic [PIX_W-1:0] pix_cnt_q;
    logic             err_ovf_q;
    logic             err_drop_q;
    logic [RW-1:0]    round_q;
    logic             rnd_load_d;
    logic [RW-1:0]    rnd_val_d;
    logic             rnd_up_d;
    logic             rnd_down_d;

    // Round index walks 1..NSYM-2 while merging, holds, then back down to 1 splitting.
    always_comb begin
        rnd_load_d = 1'b0;
        rnd_val_d  = '0;
        rnd_up_d   = 1'b0;
        rnd_down_d = 1'b0;
        case (state_q)
            ST_SORT: begin
                if (NSYM > 2) begin
                    rnd_load_d = 1'b1;
                    rnd_val_d  = RND_ONE;
                end
            end
            ST_MERGE: begin
                if (round_q != LAST_MERGE) rnd_up_d = 1'b1;
            end
            ST_SPLIT: begin
                if (round_q == RND_ONE) begin
                    rnd_load_d = 1'b1;
                    rnd_val_d  = '0;
                end else begin
                    rnd_down_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    huff_round_cnt #(.W(RW)) u_round_cnt (
        .clk        (clk),
        .rst_i      (reset),
        .load_i     (rnd_load_d),
        .load_val_i (rnd_val_d),
        .up_i       (rnd_up_d),
        .down_i     (rnd_down_d),
        .cnt_o      (round_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            err_ovf_q  <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gray_valid) begin
                        state_q    <= ST_COUNT;
                        pix_cnt_q  <= PIX_W'(1);
                        err_ovf_q  <= 1'b0;
                        err_drop_q <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (!gray_valid) begin
                        state_q <= ST_CNTV;
                    end else if (pix_cnt_q == PIX_MAX) begin
                        err_ovf_q <= 1'b1;
                    end else begin
                        pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                    end
                end
                ST_CNTV: begin
                    state_q <= ST_SORT;
                    if (gray_valid) err_drop_q <= 1'b1;
                end
                ST_SORT: begin
                    state_q <= (NSYM > 2) ? ST_MERGE : ST_CODEV;
                    if (gray_valid) err_drop_q <= 1'b1;
                end
                ST_MERGE: begin
                    if (round_q == LAST_MERGE) state_q <= ST_SPLIT;
                    if (gray_valid) err_drop_q <= 1'b1;
                end
                ST_SPLIT: begin
                    if (round_q == RND_ONE) state_q <= ST_CODEV;
                    if (gray_valid) err_drop_q <= 1'b1;
                end
                ST_CODEV: begin
                    if (code_ready) state_q <= ST_IDLE;
                    if (gray_valid) err_drop_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state      = state_q;
    assign round      = round_q;
    assign pix_cnt    = pix_cnt_q;
    assign CNT_valid  = (state_q == ST_CNTV);
    assign merge_en   = (state_q == ST_MERGE);
    assign split_en   = (state_q == ST_SPLIT);
    assign code_valid = (state_q == ST_CODEV);
    assign busy       = (state_q != ST_IDLE);
    assign err_ovf    = err_ovf_q;
    assign err_drop   = err_drop_q;

endmodule
